// File: rtl/dual_or2_74x32.sv
// dual_or2_74x32 : gates 1 and 2 of a 74x32 quad 2-input OR package, with a
// small clocked observation block for board-level checking.
//
// Ports
//   clk         observation clock (no effect on Y1/Y2)
//   rst         asynchronous active-high reset of the observation registers
//   A1, B1      gate 1 inputs
//   A2, B2      gate 2 inputs
//   Y1, Y2      combinational OR outputs, independent of clk/rst
//   Y1_q, Y2_q  Y1/Y2 registered on rising clk
//   rise1/2     registered one-cycle pulse when Y*_q goes 0->1
//   cnt1/2      saturating per-gate rising-edge counters (TOGGLE_CNT_EN only)
//
// Optional feature macro: TOGGLE_CNT_EN (adds cnt1/cnt2 and their counters).
// Parameter CNT_W (1..32) sets the counter width.

module dual_or2_74x32 #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             A1,
    input  logic             B1,
    input  logic             A2,
    input  logic             B2,
    output logic             Y1,
    output logic             Y2,
    output logic             Y1_q,
    output logic             Y2_q,
    output logic             rise1,
    output logic             rise2
`ifdef TOGGLE_CNT_EN
    ,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt2
`endif
);

    // Elaboration-time guard on the counter width.
    if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
        $error("dual_or2_74x32: CNT_W must be in 1..32");
    end

    // Gate outputs: 4-state OR already gives 1 when either input is 1 and X
    // when the other input is X/Z, so no explicit X handling is needed.
    assign Y1 = A1 | B1;
    assign Y2 = A2 | B2;

    // Rising edge of the value about to be captured versus the held sample.
    logic rise1_d;
    logic rise2_d;

    always_comb begin
        rise1_d = Y1 & ~Y1_q;
        rise2_d = Y2 & ~Y2_q;
    end

    // Observation registers; cleared state acts as the previous sample of 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Y1_q  <= 1'b0;
            Y2_q  <= 1'b0;
            rise1 <= 1'b0;
            rise2 <= 1'b0;
        end else begin
            Y1_q  <= Y1;
            Y2_q  <= Y2;
            rise1 <= rise1_d;
            rise2 <= rise2_d;
        end
    end

`ifdef TOGGLE_CNT_EN
    // Saturating rising-edge counters, updated on the same edge as the pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt1 <= '0;
            cnt2 <= '0;
        end else begin
            if (rise1_d && (cnt1 != {CNT_W{1'b1}})) begin
                cnt1 <= cnt1 + CNT_W'(1);
            end
            if (rise2_d && (cnt2 != {CNT_W{1'b1}})) begin
                cnt2 <= cnt2 + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_dual_or2_74x32.sv
// Self-checking bench for dual_or2_74x32: directed combinational/reset checks
// plus randomized clocked stimulus checked through an expectation queue.
module tb_dual_or2_74x32;

    localparam int unsigned CNT_W   = 2;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    logic A1, B1, A2, B2;
    logic Y1, Y2, Y1_q, Y2_q, rise1, rise2;
`ifdef TOGGLE_CNT_EN
    logic [CNT_W-1:0] cnt1, cnt2;
`endif

    bit clk_en = 1'b0;
    always #5 if (clk_en) clk = ~clk;

    dual_or2_74x32 #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .A1    (A1),
        .B1    (B1),
        .A2    (A2),
        .B2    (B2),
        .Y1    (Y1),
        .Y2    (Y2),
        .Y1_q  (Y1_q),
        .Y2_q  (Y2_q),
        .rise1 (rise1),
        .rise2 (rise2)
`ifdef TOGGLE_CNT_EN
        ,
        .cnt1  (cnt1),
        .cnt2  (cnt2)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected register outputs after one clock edge.
    typedef struct {
        int y1q;
        int y2q;
        int r1;
        int r2;
        int c1;
        int c2;
    } exp_t;

    exp_t sb[$];

    // Reference model: history of sampled gate values and number of rises.
    int prev1, prev2, rises1, rises2;
    bit sb_on = 1'b0;

    function automatic int sat(input int n);
        return (n > CNT_MAX) ? CNT_MAX : n;
    endfunction

    task automatic model_reset();
        prev1  = 0;
        prev2  = 0;
        rises1 = 0;
        rises2 = 0;
    endtask

    // Called just after a rising edge with the inputs that edge sampled.
    task automatic push_expect(input int a1, input int b1, input int a2, input int b2);
        exp_t e;
        int   n1, n2;
        n1 = ((a1 + b1) > 0) ? 1 : 0;
        n2 = ((a2 + b2) > 0) ? 1 : 0;
        e.r1 = (n1 == 1 && prev1 == 0) ? 1 : 0;
        e.r2 = (n2 == 1 && prev2 == 0) ? 1 : 0;
        rises1 += e.r1;
        rises2 += e.r2;
        e.y1q = n1;
        e.y2q = n2;
        e.c1  = sat(rises1);
        e.c2  = sat(rises2);
        prev1 = n1;
        prev2 = n2;
        sb.push_back(e);
    endtask

    // Monitor: registered outputs are presented every cycle; check mid-cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("Y1_q", 32'(Y1_q), 32'(e.y1q));
            check("Y2_q", 32'(Y2_q), 32'(e.y2q));
            check("rise1", 32'(rise1), 32'(e.r1));
            check("rise2", 32'(rise2), 32'(e.r2));
`ifdef TOGGLE_CNT_EN
            check("cnt1", 32'(cnt1), 32'(e.c1));
            check("cnt2", 32'(cnt2), 32'(e.c2));
`endif
        end
    end

    int ta[4] = '{1, 0, 1, 0};
    int tb[4] = '{1, 1, 0, 0};
    int ty[4] = '{1, 1, 1, 0};

    initial begin
        int a1, b1, a2, b2;
        rst = 1'b0;
        A1 = 1'b0; B1 = 1'b0; A2 = 1'b0; B2 = 1'b0;

        // Gate 1 truth table with clk idle; gate 2 held at 0.
        for (int i = 0; i < 4; i++) begin
            A1 = ta[i][0]; B1 = tb[i][0];
            #20;
            check("g1_tt_Y1", 32'(Y1), 32'(ty[i]));
            check("g1_tt_Y2", 32'(Y2), 32'(0));
        end
        // Gate 2 truth table with gate 1 held at 1.
        A1 = 1'b1; B1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            A2 = ta[i][0]; B2 = tb[i][0];
            #20;
            check("g2_tt_Y2", 32'(Y2), 32'(ty[i]));
            check("g2_tt_Y1", 32'(Y1), 32'(1));
        end
        // Independence: gate 1 at 0 while gate 2 cycles.
        A1 = 1'b0; B1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            A2 = ta[i][0]; B2 = tb[i][0];
            #20;
            check("indep_Y1", 32'(Y1), 32'(0));
        end
        // Unknown inputs.
        A1 = 1'b1; B1 = 1'bx; A2 = 1'b0; B2 = 1'bz;
        #5;
        check("x_dom_Y1", 32'(Y1), 32'(1));
        check("x_prop_Y2", 32'(Y2), 32'(1'bx));

        // Reset isolation: Y follows inputs, registers held at 0.
        rst = 1'b1;
        A1 = 1'b1; B1 = 1'b0; A2 = 1'b0; B2 = 1'b0;
        #1;
        check("rst_Y1", 32'(Y1), 32'(1));
        check("rst_Y1_q", 32'(Y1_q), 32'(0));
        check("rst_rise1", 32'(rise1), 32'(0));
        clk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_hold_Y1_q", 32'(Y1_q), 32'(0));
        check("rst_hold_rise1", 32'(rise1), 32'(0));
        check("rst_hold_Y2_q", 32'(Y2_q), 32'(0));

        // Release reset away from the edge; first edge sees prior sample 0.
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        sb_on = 1'b1;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            #1;
            if (sb_on) push_expect(a1_of(A1), a1_of(B1), a1_of(A2), a1_of(B2));
            if (i < 4) begin
                // Directed: gate 1 drops, rises once, then holds high.
                A1 = (i == 0) ? 1'b0 : 1'b1; B1 = 1'b0;
                A2 = 1'b0; B2 = 1'b0;
            end else begin
                a1 = ($urandom_range(0, 2) == 0) ? 1 : 0;
                b1 = ($urandom_range(0, 2) == 0) ? 1 : 0;
                a2 = ($urandom_range(0, 1) == 0) ? 1 : 0;
                b2 = ($urandom_range(0, 3) == 0) ? 1 : 0;
                A1 = a1[0]; B1 = b1[0]; A2 = a2[0]; B2 = b2[0];
            end
        end
        sb_on = 1'b0;
        repeat (2) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'(0));

        // Single-cycle pulse, then killed by a mid-pulse reset.
        @(posedge clk); #1;
        A1 = 1'b0; B1 = 1'b0; A2 = 1'b0; B2 = 1'b0;
        @(posedge clk); #1;
        A1 = 1'b1;
        @(posedge clk); #1;
        check("pulse_Y1_q", 32'(Y1_q), 32'(1));
        check("pulse_rise1", 32'(rise1), 32'(1));
        #1;
        rst = 1'b1;
        #1;
        check("kill_rise1", 32'(rise1), 32'(0));
        check("kill_Y1_q", 32'(Y1_q), 32'(0));
        check("kill_Y1", 32'(Y1), 32'(1));
`ifdef TOGGLE_CNT_EN
        check("kill_cnt1", 32'(cnt1), 32'(0));
`endif
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_rise1", 32'(rise1), 32'(1));
        @(posedge clk); #1;
        check("post_rst_rise1_end", 32'(rise1), 32'(0));

        clk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    function automatic int a1_of(input logic v);
        return (v === 1'b1) ? 1 : 0;
    endfunction

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
